// File: rtl/rom_stream_packer.sv
// rom_stream_packer
//   Streams TOTAL_WORDS words out of the auto-incrementing weight ROM and packs
//   every LANES consecutive words into one vector for the PE-array loader.
//   The ROM has a 1-cycle registered read, so a word issued with rom_en in
//   cycle n is captured in cycle n+1 (tracked by en_d_q). rom_en is throttled
//   so that a group can only complete when the output register is free,
//   which means no ROM word is ever dropped or duplicated under backpressure.
//
//   state | meaning
//   IDLE  | waiting for start; done pulses here for one cycle after a load
//   FETCH | issuing ROM reads, packing returned words
//   FLUSH | all reads issued; draining last capture and final handshake
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                begin one load (sampled only in IDLE)
//   busy, done           status: in FETCH/FLUSH, 1-cycle completion pulse
//   rom_en, rom_dout     ROM read enable / data (data valid cycle after rom_en)
//   out_data, out_valid  packed vector (word k in bits [k*DW +: DW]) and valid
//   out_ready            consumer ready
module rom_stream_packer #(
    parameter int DATA_BITWIDTH = 8,
    parameter int LANES         = 4,
    parameter int TOTAL_WORDS   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             rom_en,
    input  logic [DATA_BITWIDTH-1:0]         rom_dout,
    output logic [LANES*DATA_BITWIDTH-1:0]   out_data,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int DW = DATA_BITWIDTH;
    localparam int LW = $clog2(LANES);
    localparam int CW = $clog2(TOTAL_WORDS + 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [CW-1:0] TOTAL     = CW'(TOTAL_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  issued_q, issued_d;
    logic [CW-1:0]                  captured_q, captured_d;
    logic [LW-1:0]                  lane_idx_q, lane_idx_d;
    logic                           en_d_q, en_d_d;
    logic [LANES-2:0][DW-1:0]       pack_q, pack_d;
    logic [LANES*DW-1:0]            out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;
    logic                           done_q, done_d;

    logic                           rom_en_c;
    logic [LW:0]                    pend;
    logic                           room;

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        captured_d  = captured_q;
        lane_idx_d  = lane_idx_q;
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        rom_en_c    = 1'b0;

        // Words already packed plus the one arriving this cycle. Only when
        // this read could complete a group must the output register be free
        // (or be emptied by a handshake this cycle).
        pend = {1'b0, lane_idx_q} + {{LW{1'b0}}, en_d_q};
        room = (pend < {1'b0, LANE_LAST}) || !out_valid_q || out_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    issued_d   = '0;
                    captured_d = '0;
                    lane_idx_d = '0;
                end
            end
            S_FETCH: begin
                rom_en_c = (issued_q < TOTAL) && room;
                if (issued_q == TOTAL) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if ((captured_q == TOTAL) && out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rom_en_c) begin
            issued_d = issued_q + CW'(1);
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A completing group overrides the handshake clear above, so a new
        // vector can follow the old one back-to-back.
        if (en_d_q) begin
            captured_d = captured_q + CW'(1);
            if (lane_idx_q == LANE_LAST) begin
                out_data_d  = {rom_dout, pack_q};
                out_valid_d = 1'b1;
                lane_idx_d  = '0;
            end else begin
                pack_d[lane_idx_q] = rom_dout;
                lane_idx_d         = lane_idx_q + LW'(1);
            end
        end

        en_d_d = rom_en_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issued_q    <= '0;
            captured_q  <= '0;
            lane_idx_q  <= '0;
            en_d_q      <= 1'b0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            captured_q  <= captured_d;
            lane_idx_q  <= lane_idx_d;
            en_d_q      <= en_d_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_q ? 1'b0 : done_d;
        end
    end

    assign rom_en    = rom_en_c;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
